// File: rtl/sram_param.sv
`default_nettype none
// ============================================================================
// sram_param : single-port synchronous SRAM, per-lane write enables, 1/2-cycle
//              read latency, RDW mode and post-reset zero-fill sweep.
// Rev 1.0
// ============================================================================
module sram_param #(
  parameter int DATA_W   = 8,
  parameter int LANE_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       WE,
  input  logic                       RD,
  input  logic [ADDR_W-1:0]          Addr,
  input  logic [DATA_W-1:0]          dataIn,
  input  logic [DATA_W/LANE_W-1:0]   byteEn,
  output logic [DATA_W-1:0]          dataOut,
  output logic                       rdValid,
  output logic                       ready
);

  localparam int                c_NLANE   = DATA_W / LANE_W;
  localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W + 1)'(DEPTH);
  localparam logic [0:0]        c_ST_INIT = 1'b0;
  localparam logic [0:0]        c_ST_RUN  = 1'b1;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_last;
  logic              w_init_wr;
  logic              w_run;
  logic              w_in_range;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rdata;
  logic              w_out_vld;
  logic [DATA_W-1:0] w_out_data;

  assign w_last = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_ST_INIT && w_last) w_state_nxt = c_ST_RUN;
  end

  always_comb begin
    w_init_wr = (r_state == c_ST_INIT);
    w_run     = (r_state == c_ST_RUN);
    ready     = w_run;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (w_init_wr && !w_last) r_cnt <= r_cnt + ADDR_W'(1);
  end

  assign w_in_range = ({1'b0, Addr} < c_DEPTH);
  assign w_wr       = w_run & WE & w_in_range;
  assign w_rd       = w_run & RD;
  assign w_old      = w_in_range ? r_mem[Addr] : '0;

  // Post-write view of the addressed word, used for write-first reads.
  for (genvar i = 0; i < c_NLANE; i++) begin : g_lane
    assign w_merged[i*LANE_W +: LANE_W] = byteEn[i] ? dataIn[i*LANE_W +: LANE_W]
                                                    : w_old[i*LANE_W +: LANE_W];
  end

  assign w_rdata = (RDW_MODE != 0 && w_wr) ? w_merged : w_old;

  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < c_NLANE; i++) begin
        if (byteEn[i]) r_mem[Addr][i*LANE_W +: LANE_W] <= dataIn[i*LANE_W +: LANE_W];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              r_p1_vld;
    logic [DATA_W-1:0] r_p1_data;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_p1_vld  <= 1'b0;
        r_p1_data <= '0;
      end else begin
        r_p1_vld <= w_rd;
        if (w_rd) r_p1_data <= w_rdata;
      end
    end
    assign w_out_vld  = r_p1_vld;
    assign w_out_data = r_p1_data;
  end else begin : g_lat1
    assign w_out_vld  = w_rd;
    assign w_out_data = w_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= w_out_vld;
      if (w_out_vld) dataOut <= w_out_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_param.sv
`default_nettype none
// ============================================================================
// tb_sram_param : directed bench driving a default instance (A) and a
//                 16-bit / DEPTH=6 / RD_LAT=2 / write-first instance (B).
// ============================================================================
module tb_sram_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WE, RD;
  logic [2:0]  Addr;
  logic [15:0] dataIn;
  logic [1:0]  byteEn;

  logic [7:0]  a_dout;
  logic        a_vld, a_rdy;
  logic [15:0] b_dout;
  logic        b_vld, b_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_param u_a (
    .clk(clk), .rst_n(rst_n), .WE(WE), .RD(RD), .Addr(Addr),
    .dataIn(dataIn[7:0]), .byteEn(byteEn[0:0]),
    .dataOut(a_dout), .rdValid(a_vld), .ready(a_rdy)
  );

  sram_param #(
    .DATA_W(16), .LANE_W(8), .ADDR_W(3), .DEPTH(6), .RD_LAT(2), .RDW_MODE(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .WE(WE), .RD(RD), .Addr(Addr),
    .dataIn(dataIn), .byteEn(byteEn),
    .dataOut(b_dout), .rdValid(b_vld), .ready(b_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic we, input logic rd, input logic [2:0] a,
                    input logic [15:0] d, input logic [1:0] be);
    WE = we; RD = rd; Addr = a; dataIn = d; byteEn = be;
    tick();
  endtask

  task automatic wait_sweep();
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("a_ready_e%0d", i), 32'(a_rdy), 32'(i >= 8));
      check($sformatf("b_ready_e%0d", i), 32'(b_rdy), 32'(i >= 6));
    end
  endtask

  task automatic read_zero_sweep();
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 3'(i), 16'h0, 2'b00);
      check($sformatf("a_zero_vld%0d", i), 32'(a_vld), 32'h1);
      check($sformatf("a_zero_dat%0d", i), 32'(a_dout), 32'h0);
      if (i > 0) begin
        check($sformatf("b_zero_vld%0d", i - 1), 32'(b_vld), 32'h1);
        check($sformatf("b_zero_dat%0d", i - 1), 32'(b_dout), 32'h0);
      end
    end
    op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    check("a_zero_vld_end", 32'(a_vld), 32'h0);
    check("b_zero_vld7", 32'(b_vld), 32'h1);
    check("b_zero_dat7", 32'(b_dout), 32'h0);
    tick();
    check("b_zero_vld_end", 32'(b_vld), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; WE = 1'b0; RD = 1'b0; Addr = '0; dataIn = '0; byteEn = '0;
    tick(); tick();
    check("rst_a_dout", 32'(a_dout), 32'h0);
    check("rst_a_vld",  32'(a_vld),  32'h0);
    check("rst_a_rdy",  32'(a_rdy),  32'h0);
    check("rst_b_dout", 32'(b_dout), 32'h0);
    check("rst_b_rdy",  32'(b_rdy),  32'h0);
    rst_n = 1'b1;
    wait_sweep();
    read_zero_sweep();

    // full-word write then read, output holds afterwards
    op(1'b1, 1'b0, 3'd0, 16'h00FF, 2'b11);
    op(1'b0, 1'b1, 3'd0, 16'h0, 2'b00);
    check("wr0_a_vld", 32'(a_vld),  32'h1);
    check("wr0_a_dat", 32'(a_dout), 32'hFF);
    op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    check("wr0_a_hold_vld", 32'(a_vld),  32'h0);
    check("wr0_a_hold_dat", 32'(a_dout), 32'hFF);
    check("wr0_b_vld",      32'(b_vld),  32'h1);
    check("wr0_b_dat",      32'(b_dout), 32'h00FF);
    tick();
    check("wr0_b_hold_vld", 32'(b_vld),  32'h0);
    check("wr0_b_hold_dat", 32'(b_dout), 32'h00FF);

    // lane enables: ABCD/11, 1234/01, FFFF/00
    op(1'b1, 1'b0, 3'd2, 16'hABCD, 2'b11);
    op(1'b1, 1'b0, 3'd2, 16'h1234, 2'b01);
    op(1'b1, 1'b0, 3'd2, 16'hFFFF, 2'b00);
    op(1'b0, 1'b1, 3'd2, 16'h0, 2'b00);
    check("lane_a_dat", 32'(a_dout), 32'h34);
    op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    check("lane_b_vld", 32'(b_vld),  32'h1);
    check("lane_b_dat", 32'(b_dout), 32'hAB34);

    // read-during-write on Addr 5: A read-first, B write-first
    op(1'b1, 1'b0, 3'd5, 16'h0011, 2'b11);
    op(1'b1, 1'b1, 3'd5, 16'h0022, 2'b11);
    check("rdw_a_old", 32'(a_dout), 32'h11);
    op(1'b0, 1'b1, 3'd5, 16'h0, 2'b00);
    check("rdw_a_next", 32'(a_dout), 32'h22);
    check("rdw_b_new",  32'(b_dout), 32'h0022);
    op(1'b1, 1'b1, 3'd5, 16'h3344, 2'b10);
    check("rdw_a_nolane", 32'(a_dout), 32'h22);
    check("rdw_b_next",   32'(b_dout), 32'h0022);
    op(1'b0, 1'b1, 3'd5, 16'h0, 2'b00);
    check("rdw_a_after", 32'(a_dout), 32'h22);
    check("rdw_b_merge", 32'(b_dout), 32'h3322);
    op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    check("rdw_b_after", 32'(b_dout), 32'h3322);

    // back-to-back reads, latency 1 vs 2
    op(1'b1, 1'b0, 3'd1, 16'h000A, 2'b11);
    op(1'b1, 1'b0, 3'd2, 16'h000B, 2'b11);
    op(1'b1, 1'b0, 3'd3, 16'h000C, 2'b11);
    op(1'b0, 1'b1, 3'd1, 16'h0, 2'b00);
    check("b2b_a_1",   32'(a_dout), 32'h0A);
    check("b2b_b_vld0", 32'(b_vld), 32'h0);
    op(1'b0, 1'b1, 3'd2, 16'h0, 2'b00);
    check("b2b_a_2", 32'(a_dout), 32'h0B);
    check("b2b_b_1", 32'({b_vld, b_dout}), 32'h1000A);
    op(1'b0, 1'b1, 3'd3, 16'h0, 2'b00);
    check("b2b_a_3", 32'({a_vld, a_dout}), 32'h10C);
    check("b2b_b_2", 32'({b_vld, b_dout}), 32'h1000B);
    op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    check("b2b_a_end", 32'(a_vld), 32'h0);
    check("b2b_b_3",   32'({b_vld, b_dout}), 32'h1000C);
    tick();
    check("b2b_b_end", 32'({b_vld, b_dout}), 32'h0000C);

    // Addr 7: in range for A, out of range for B
    op(1'b1, 1'b0, 3'd7, 16'h0055, 2'b11);
    op(1'b0, 1'b1, 3'd7, 16'h0, 2'b00);
    check("oor_a_dat", 32'({a_vld, a_dout}), 32'h155);
    op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    check("oor_b_dat", 32'({b_vld, b_dout}), 32'h10000);

    // asynchronous reset with a read in flight
    op(1'b0, 1'b1, 3'd1, 16'h0, 2'b00);
    check("mid_a_pre", 32'({a_vld, a_dout}), 32'h10A);
    rst_n = 1'b0;
    #1;
    check("mid_a_vld",  32'(a_vld),  32'h0);
    check("mid_a_dout", 32'(a_dout), 32'h0);
    check("mid_a_rdy",  32'(a_rdy),  32'h0);
    check("mid_b_vld",  32'(b_vld),  32'h0);
    check("mid_b_rdy",  32'(b_rdy),  32'h0);
    RD = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_sweep();
    read_zero_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_param.md
# sram_param

Parametrised single-port synchronous SRAM, the next generation of the team's 8×8 `SRAM`. It generalises width and depth and adds per-lane write enables, selectable read latency and a defined read-during-write mode. It also adds a reset-triggered zero-fill sweep with a ready flag, and a read-valid strobe. It sits between datapath blocks and storage wherever a small scratch memory with deterministic post-reset contents is needed.

## Interface
- DATA_W, 8, data width in bits; must be a multiple of LANE_W
- LANE_W, 8, bits per write-enable lane; NLANE = DATA_W/LANE_W
- ADDR_W, 3, address width
- DEPTH, 2**ADDR_W, number of words; 1 ≤ DEPTH ≤ 2**ADDR_W
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- RDW_MODE, 0, same-address read-during-write: 0 = read-first (old data), 1 = write-first (new data)

- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- WE  input  1  write request
- RD  input  1  read request
- Addr  input  ADDR_W  word address, shared by read and write
- dataIn  input  DATA_W  write data
- byteEn  input  NLANE  lane write enables; lane i covers dataIn[i*LANE_W +: LANE_W]
- dataOut  output  DATA_W  registered read data
- rdValid  output  1  one-cycle strobe marking a new value on dataOut
- ready  output  1  high once the zero-fill sweep is complete

## Operation
- FSM states: INIT and RUN.
- Reset assertion puts the FSM in INIT and clears the sweep counter, dataOut, rdValid, ready and all pipeline registers to 0. Takes effect immediately (asynchronous).
- INIT:
  - Each cycle, writes 0 to mem[cnt] and increments cnt.
  - After writing DEPTH-1, moves to RUN; ready = 1 from that edge.
  - WE and RD are ignored; rdValid stays 0.
- RUN, write: at a rising edge with WE=1, mem[Addr] lane i <= dataIn lane i for each i with byteEn[i]=1. Other lanes are unchanged.
  - byteEn = 0 means no change.
- RUN, read: at a rising edge with RD=1, the word at Addr is read. It appears on dataOut with rdValid=1 per the latency rule in Timing.
- WE and RD may be asserted in the same cycle.
  - Different addresses: the operations are independent.
  - Same address: RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the merged post-write word, with unenabled lanes taken from the old word.
- Out-of-range Addr (Addr ≥ DEPTH):
  - A write is dropped.
  - A read returns all-zero data with rdValid=1.
- dataOut holds the last read value until the next read completes. It never returns to 0 except on reset.
- Reset mid-operation:
  - In-flight reads are discarded (rdValid=0).
  - Memory is re-zeroed by a fresh INIT sweep.
  - Writes in progress at reset are lost.

## Timing
- Reset values: dataOut=0, rdValid=0, ready=0.
- After rst_n deasserts, INIT takes exactly DEPTH rising edges. ready rises after the DEPTH-th edge. The first accepted request is sampled on the following edge.
- RD sampled at edge k:
  - dataOut/rdValid update after edge k+RD_LAT-1, i.e. visible in the cycle after edge k for RD_LAT=1, one cycle later for RD_LAT=2.
- rdValid is high for exactly one cycle per accepted read. Back-to-back reads give back-to-back strobes at full throughput (one read per cycle).
- Writes are visible to a read sampled on any later edge.
- Same-edge visibility is governed by RDW_MODE.
- No combinational path exists from inputs to outputs.

## Test plan
- Reset then idle, defaults: ready=0 for 8 edges, then 1. A read of each address 0..7 returns 0x00 with rdValid pulsing once per read.
- Defaults: write 0xFF to Addr 0, then RD Addr 0 → dataOut=0xFF with rdValid on the first cycle after the read edge. The value holds with rdValid=0 afterwards.
- DATA_W=16, LANE_W=8: write 0xABCD with byteEn=11, then write 0x1234 with byteEn=01 → read returns 0xAB34.
- Simultaneous WE+RD, Addr 5, old word 0x11, new word 0x22: RDW_MODE=0 → dataOut=0x11; RDW_MODE=1 → 0x22. A following read returns 0x22 in both modes.
- RD_LAT=2, reads of Addr 1,2,3 on consecutive edges holding 0x0A,0x0B,0x0C → outputs appear 2 cycles after each read edge, on three consecutive cycles with rdValid high throughout.
- DEPTH=6, ADDR_W=3: write 0x55 to Addr 7 → dropped; read Addr 7 → 0x00 with rdValid. Then assert rst_n low mid-read → rdValid=0 and ready=0 at once, and all words read 0 after the new sweep.
